// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Brief    : Round-robin scheduler sharing one W x W sequential multiplier
//            between two requesters. It issues one job at a time over the
//            multiplier's start/ready handshake and returns each product to
//            the requester that owns it.
// Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic             req1,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [2*W-1:0]   p0,
    output logic [2*W-1:0]   p1,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic             mul_ready,
    input  logic [2*W-1:0]   mul_product,
    output logic             busy
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_issue = 3'd1;
    localparam logic [2:0] c_run   = 3'd2;
    localparam logic [2:0] c_wait  = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    logic [2:0]     r_state;
    logic           r_owner;
    logic           r_last;
    logic           r_ack0;
    logic           r_ack1;
    logic           r_done0;
    logic           r_done1;
    logic           r_mul_start;
    logic           r_busy;
    logic [W-1:0]   r_mul_a;
    logic [W-1:0]   r_mul_b;
    logic [2*W-1:0] r_p0;
    logic [2*W-1:0] r_p1;

    logic           w_any_req;
    logic           w_sel;

    // Grant selection: a lone requester wins; on a tie the one not served last wins.
    assign w_any_req = req0 | req1;
    assign w_sel     = (req0 & req1) ? ~r_last : req1;

    // Sequencer: arbitration in IDLE, then issue, wait for the multiplier to
    // drop ready (so a stale ready is ignored), capture on ready rising, report.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= c_idle;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_mul_start <= 1'b0;
            r_busy      <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_p0        <= '0;
            r_p1        <= '0;
        end else begin
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_mul_start <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_any_req) begin
                        r_owner     <= w_sel;
                        r_last      <= w_sel;
                        r_mul_a     <= w_sel ? a1 : a0;
                        r_mul_b     <= w_sel ? b1 : b0;
                        r_mul_start <= 1'b1;
                        r_ack0      <= ~w_sel;
                        r_ack1      <= w_sel;
                        r_busy      <= 1'b1;
                        r_state     <= c_issue;
                    end
                end
                c_issue: begin
                    r_state <= c_run;
                end
                c_run: begin
                    if (!mul_ready) begin
                        r_state <= c_wait;
                    end
                end
                c_wait: begin
                    if (mul_ready) begin
                        if (r_owner) begin
                            r_p1 <= mul_product;
                        end else begin
                            r_p0 <= mul_product;
                        end
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign p0        = r_p0;
    assign p1        = r_p1;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arbiter
// Brief    : Self-checking bench for mult_arbiter with a behavioural
//            multiplier (configurable stale-ready and latency) and a
//            scoreboard of expected grants and products.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic             req0, req1;
    logic [W-1:0]     a0, b0, a1, b1;
    logic             ack0, ack1, done0, done1;
    logic [2*W-1:0]   p0, p1;
    logic             mul_start;
    logic [W-1:0]     mul_a, mul_b;
    logic             mul_ready = 1'b1;
    logic [2*W-1:0]   mul_product = '0;
    logic             busy;

    int total = 0;
    int bad   = 0;

    // Multiplier model knobs: extra cycles ready stays high after start, and ready-low duration.
    int stale_cyc = 0;
    int lat_cyc   = 1;

    // Scoreboard
    logic [2*W-1:0] ref_p0, ref_p1;
    logic           ref_last;

    mult_arbiter #(.W(W)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .p0(p0), .p1(p1),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_product(mul_product),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural sequential multiplier
    logic [W-1:0] m_a = '0, m_b = '0;
    int m_phase = 0;
    int m_cnt   = 0;
    always @(posedge clk) begin
        if (clr) begin
            m_phase   <= 0;
            mul_ready <= 1'b1;
        end else if (mul_start) begin
            m_a     <= mul_a;
            m_b     <= mul_b;
            m_phase <= 1;
            m_cnt   <= stale_cyc;
        end else if (m_phase == 1) begin
            if (m_cnt == 0) begin
                mul_ready <= 1'b0;
                m_phase   <= 2;
                m_cnt     <= lat_cyc;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (m_phase == 2) begin
            if (m_cnt <= 1) begin
                mul_ready   <= 1'b1;
                mul_product <= {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
                m_phase     <= 0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) * int'(y);
        return r[2*W-1:0];
    endfunction

    task automatic apply_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr      = 1'b0;
        ref_p0   = '0;
        ref_p1   = '0;
        ref_last = 1'b1;
    endtask

    // who: 0/1 granted, 2 both, -1 timeout; n: negedges waited; st: mul_start with ack
    task automatic wait_ack(output int who, output int n, output logic st);
        who = -1; n = 0; st = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack0 | ack1) begin
                who = (ack0 & ack1) ? 2 : (ack1 ? 1 : 0);
                n   = i;
                st  = mul_start;
                return;
            end
        end
    endtask

    // who as above for done; stable: mul_a/mul_b unchanged until done
    task automatic wait_done(output int who, output int n, output logic stable);
        logic [W-1:0] sa, sb;
        sa = mul_a; sb = mul_b;
        who = -1; n = 0; stable = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done0 | done1) begin
                who = (done0 & done1) ? 2 : (done1 ? 1 : 0);
                n   = i;
                return;
            end
            if (mul_a !== sa || mul_b !== sb) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        total++;
        if ({busy, ack0, ack1, done0, done1, mul_start} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000", {busy, ack0, ack1, done0, done1, mul_start});
        end
        total++;
        if (p0 !== '0 || p1 !== '0) begin
            bad++;
            $display("FAIL reset_p got p0=%h p1=%h want 0 0", p0, p1);
        end
        total++;
        if (mul_a !== '0 || mul_b !== '0) begin
            bad++;
            $display("FAIL reset_ops got a=%h b=%h want 0 0", mul_a, mul_b);
        end
    endtask

    task automatic test_single();
        int who, n; logic st, stb;
        stale_cyc = 0; lat_cyc = 1;
        a0 = 4'd3; b0 = 4'd5; req0 = 1'b1;
        wait_ack(who, n, st);
        req0 = 1'b0;
        total++;
        if (who !== 0 || n !== 1 || st !== 1'b1) begin
            bad++;
            $display("FAIL single_ack got who=%0d n=%0d start=%b want 0 1 1", who, n, st);
        end
        wait_done(who, n, stb);
        total++;
        if (who !== 0 || n !== 3 + stale_cyc + lat_cyc) begin
            bad++;
            $display("FAIL single_done got who=%0d span=%0d want 0 %0d", who, n, 3 + stale_cyc + lat_cyc);
        end
        ref_p0 = prod(4'd3, 4'd5);
        total++;
        if (p0 !== 8'h0F || p1 !== ref_p1) begin
            bad++;
            $display("FAIL single_p got p0=%h p1=%h want 0f %h", p0, p1, ref_p1);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got busy=%b done0=%b want 0 0", busy, done0);
        end
    endtask

    task automatic test_max();
        int who, n; logic st, stb;
        a1 = 4'd15; b1 = 4'd15; req1 = 1'b1;
        wait_ack(who, n, st);
        req1 = 1'b0;
        total++;
        if (who !== 1 || n !== 1 || st !== 1'b1 || mul_a !== 4'd15 || mul_b !== 4'd15) begin
            bad++;
            $display("FAIL max_ack got who=%0d n=%0d start=%b a=%h b=%h want 1 1 1 f f", who, n, st, mul_a, mul_b);
        end
        wait_done(who, n, stb);
        ref_p1 = prod(4'd15, 4'd15);
        total++;
        if (who !== 1 || stb !== 1'b1) begin
            bad++;
            $display("FAIL max_done got who=%0d stable=%b want 1 1", who, stb);
        end
        total++;
        if (p1 !== 8'hE1 || p0 !== ref_p0) begin
            bad++;
            $display("FAIL max_p got p1=%h p0=%h want e1 %h", p1, p0, ref_p0);
        end
    endtask

    task automatic test_roundrobin();
        int who, n, want; logic st, stb;
        apply_reset();
        a0 = 4'd2; b0 = 4'd7; a1 = 4'd9; b1 = 4'd4;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            want = ref_last ? 0 : 1;
            wait_ack(who, n, st);
            total++;
            if (who !== want || n !== (k == 0 ? 1 : 2)) begin
                bad++;
                $display("FAIL rr_ack%0d got who=%0d n=%0d want %0d %0d", k, who, n, want, (k == 0 ? 1 : 2));
            end
            ref_last = want[0];
            wait_done(who, n, stb);
            if (want == 0) ref_p0 = prod(a0, b0); else ref_p1 = prod(a1, b1);
            total++;
            if (who !== want || p0 !== ref_p0 || p1 !== ref_p1) begin
                bad++;
                $display("FAIL rr_done%0d got who=%0d p0=%h p1=%h want %0d %h %h", k, who, p0, p1, want, ref_p0, ref_p1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_stale();
        int who, n; logic st, stb;
        stale_cyc = 3; lat_cyc = 2;
        a0 = 4'd5; b0 = 4'd11; req0 = 1'b1;
        wait_ack(who, n, st);
        req0 = 1'b0;
        wait_done(who, n, stb);
        ref_p0 = prod(4'd5, 4'd11);
        total++;
        if (who !== 0 || n !== 3 + 3 + 2 || p0 !== ref_p0) begin
            bad++;
            $display("FAIL stale got who=%0d span=%0d p0=%h want 0 8 %h", who, n, p0, ref_p0);
        end
    endtask

    task automatic test_reset_midjob();
        int who, n, pulses; logic st, stb;
        stale_cyc = 0; lat_cyc = 4;
        @(negedge clk);
        a0 = 4'd7; b0 = 4'd3; req0 = 1'b1;
        wait_ack(who, n, st);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1 || mul_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_inflight got busy=%b ready=%b want 1 0", busy, mul_ready);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        ref_p0 = '0; ref_p1 = '0; ref_last = 1'b1;
        total++;
        if (busy !== 1'b0 || p0 !== '0 || p1 !== '0 || done0 !== 1'b0 || done1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got busy=%b p0=%h p1=%h done=%b%b want 0 0 0 00", busy, p0, p1, done0, done1);
        end
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done0 | done1 | ack0 | ack1) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL mid_quiet got pulses=%0d want 0", pulses);
        end
        lat_cyc = 1;
        a0 = 4'd6; b0 = 4'd6; req0 = 1'b1;
        wait_ack(who, n, st);
        req0 = 1'b0;
        wait_done(who, n, stb);
        ref_p0 = prod(4'd6, 4'd6);
        total++;
        if (who !== 0 || p0 !== 8'd36) begin
            bad++;
            $display("FAIL mid_after got who=%0d p0=%h want 0 24", who, p0);
        end
    endtask

    task automatic test_zero();
        int who, n; logic st, stb;
        stale_cyc = 0; lat_cyc = 1;
        @(negedge clk);
        a0 = 4'd0; b0 = 4'd13; req0 = 1'b1;
        wait_ack(who, n, st);
        req0 = 1'b0;
        total++;
        if (who !== 0 || n !== 1 || st !== 1'b1) begin
            bad++;
            $display("FAIL zero_ack got who=%0d n=%0d start=%b want 0 1 1", who, n, st);
        end
        wait_done(who, n, stb);
        ref_p0 = '0;
        total++;
        if (who !== 0 || n !== 4 || p0 !== 8'd0 || p1 !== ref_p1) begin
            bad++;
            $display("FAIL zero_done got who=%0d span=%0d p0=%h p1=%h want 0 4 0 %h", who, n, p0, p1, ref_p1);
        end
    endtask

    task automatic test_random();
        int who, n, want;
        logic st, stb, pend0, pend1;
        logic [2*W-1:0] want_p;
        pend0 = 1'b0; pend1 = 1'b0;
        for (int it = 0; it < 30; it++) begin
            if (!pend0 && $urandom_range(1, 0) == 1) begin
                pend0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom);
            end
            if (!pend1 && $urandom_range(1, 0) == 1) begin
                pend1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom);
            end
            if (!pend0 && !pend1) begin
                pend1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom);
            end
            req0 = pend0; req1 = pend1;
            want = (pend0 && pend1) ? (ref_last ? 0 : 1) : (pend1 ? 1 : 0);
            wait_ack(who, n, st);
            total++;
            if (who !== want || st !== 1'b1) begin
                bad++;
                $display("FAIL rand_ack%0d got who=%0d start=%b want %0d 1", it, who, st, want);
            end
            ref_last = want[0];
            stale_cyc = int'($urandom_range(3, 0));
            lat_cyc   = int'($urandom_range(4, 1));
            if (want == 0) begin
                want_p = prod(a0, b0); pend0 = 1'b0; req0 = 1'b0;
            end else begin
                want_p = prod(a1, b1); pend1 = 1'b0; req1 = 1'b0;
            end
            wait_done(who, n, stb);
            if (want == 0) ref_p0 = want_p; else ref_p1 = want_p;
            total++;
            if (who !== want || n !== 3 + stale_cyc + lat_cyc || stb !== 1'b1 ||
                p0 !== ref_p0 || p1 !== ref_p1) begin
                bad++;
                $display("FAIL rand_done%0d got who=%0d span=%0d stable=%b p0=%h p1=%h want %0d %0d 1 %h %h",
                         it, who, n, stb, p0, p1, want, 3 + stale_cyc + lat_cyc, ref_p0, ref_p1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        apply_reset();
        test_reset();
        test_single();
        test_max();
        test_roundrobin();
        test_stale();
        test_reset_midjob();
        test_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
